// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time game controller.
//   state_t    : controller FSM states
//   TIME_W_DEF : default width of millisecond time values
package reaction_pkg;

    localparam int TIME_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        GO     = 3'd2,
        RESULT = 3'd3,
        FOUL   = 3'd4,
        TOUT   = 3'd5
    } state_t;

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: divides clk by TICK_DIV and flags the last cycle
// of each period with a one-cycle tick.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   clr  : holds the prescaler at zero (and suppresses tick) while high
//   tick : high in the last clk cycle of every TICK_DIV-cycle period
module ms_tick #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    // Prescaler counter: wraps after TICK_DIV cycles, parked at zero by clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= ZERO;
        end else if (clr) begin
            cnt <= ZERO;
        end else if (cnt == LAST) begin
            cnt <= ZERO;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    // Tick is decoded from the registered count, so the consumer advances
    // on the same edge that wraps the prescaler.
    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time game controller.
// A round: start_btn arms the external delay block (delay_flag); when it
// reports delay_done the LED turns on and milliseconds are counted until
// react_btn. Pressing early is a foul; no press within TIMEOUT_MS abandons
// the round. The fastest reaction since reset/clear_best is kept.
//   clk, rst      : clock and asynchronous active-high reset
//   start_btn     : pulse, starts a round from IDLE/FOUL/TOUT
//   react_btn     : pulse, player reaction
//   clear_best    : pulse, forgets the best time
//   delay_done    : level, pre-LED delay has elapsed
//   delay_flag    : level, asks the delay block to run/hold its delay
//   led_on        : reaction LED
//   react_time    : last measured reaction (ms)
//   best_time     : best reaction, all-ones when none
//   result_valid  : one-cycle pulse with each new react_time
//   foul, timeout : round ended by early press / no press
//   busy          : round in progress (arming or LED on)
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int TICK_DIV   = 100000,
    parameter int TIME_W     = TIME_W_DEF,
    parameter int TIMEOUT_MS = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_btn,
    input  logic              react_btn,
    input  logic              clear_best,
    input  logic              delay_done,
    output logic              delay_flag,
    output logic              led_on,
    output logic [TIME_W-1:0] react_time,
    output logic [TIME_W-1:0] best_time,
    output logic              result_valid,
    output logic              foul,
    output logic              timeout,
    output logic              busy
);

    localparam logic [TIME_W-1:0] TIME_MAX  = {TIME_W{1'b1}};
    localparam logic [TIME_W-1:0] TIME_ZERO = {TIME_W{1'b0}};
    localparam logic [TIME_W-1:0] TIME_ONE  = TIME_W'(1);
    localparam logic [TIME_W-1:0] TIMEOUT_V = TIME_W'(TIMEOUT_MS);

    state_t            state;
    state_t            next_state;
    logic [TIME_W-1:0] ms_cnt;
    logic              tick;
    logic              tick_clr;
    logic              capture;

    // Prescaler and ms counter only run in GO, so both start from zero on
    // every GO entry.
    assign tick_clr = (state != GO);
    assign capture  = (state == GO) && react_btn;

    ms_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_ms_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Elapsed milliseconds since LED-on; saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ms_cnt <= TIME_ZERO;
        end else if (state != GO) begin
            ms_cnt <= TIME_ZERO;
        end else if (tick && (ms_cnt != TIME_MAX)) begin
            ms_cnt <= ms_cnt + TIME_ONE;
        end else begin
            ms_cnt <= ms_cnt;
        end
    end

    // Next-state decode; reaction presses take priority over delay_done in
    // ARM and over the timeout check in GO.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, FOUL, TOUT: begin
                if (start_btn) begin
                    next_state = ARM;
                end else begin
                    next_state = state;
                end
            end
            ARM: begin
                if (react_btn) begin
                    next_state = FOUL;
                end else if (delay_done) begin
                    next_state = GO;
                end else begin
                    next_state = ARM;
                end
            end
            GO: begin
                if (react_btn) begin
                    next_state = RESULT;
                end else if (ms_cnt >= TIMEOUT_V) begin
                    next_state = TOUT;
                end else begin
                    next_state = GO;
                end
            end
            RESULT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register with outputs registered from the next state, so each
    // output is valid in exactly the cycles its state is current.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            delay_flag   <= 1'b0;
            led_on       <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            foul         <= 1'b0;
            timeout      <= 1'b0;
            react_time   <= TIME_ZERO;
            best_time    <= TIME_MAX;
        end else begin
            state        <= next_state;
            delay_flag   <= (next_state == ARM) || (next_state == GO);
            busy         <= (next_state == ARM) || (next_state == GO);
            led_on       <= (next_state == GO);
            result_valid <= (next_state == RESULT);
            foul         <= (next_state == FOUL);
            timeout      <= (next_state == TOUT);

            if (capture) begin
                react_time <= ms_cnt;
            end else begin
                react_time <= react_time;
            end

            // A result arriving with clear_best becomes the new best outright.
            if (capture && (clear_best || (ms_cnt < best_time))) begin
                best_time <= ms_cnt;
            end else if (clear_best) begin
                best_time <= TIME_MAX;
            end else begin
                best_time <= best_time;
            end
        end
    end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl (TICK_DIV=4, TIMEOUT_MS=10, TIME_W=8).
// A round-level model predicts every output on each falling edge; literal
// expectations at key points pin the model down.
module tb_reaction_ctrl;

    localparam int TD = 4;
    localparam int TW = 8;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_btn = 1'b0;
    logic          react_btn = 1'b0;
    logic          clear_best = 1'b0;
    logic          delay_done = 1'b0;
    logic          delay_flag;
    logic          led_on;
    logic [TW-1:0] react_time;
    logic [TW-1:0] best_time;
    logic          result_valid;
    logic          foul;
    logic          timeout;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reaction_ctrl #(
        .TICK_DIV   (TD),
        .TIME_W     (TW),
        .TIMEOUT_MS (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_btn    (start_btn),
        .react_btn    (react_btn),
        .clear_best   (clear_best),
        .delay_done   (delay_done),
        .delay_flag   (delay_flag),
        .led_on       (led_on),
        .react_time   (react_time),
        .best_time    (best_time),
        .result_valid (result_valid),
        .foul         (foul),
        .timeout      (timeout),
        .busy         (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- round-level model ----------------
    typedef enum {M_IDLE, M_ARM, M_GO, M_RES, M_FOUL, M_TOUT} phase_t;
    phase_t m_ph   = M_IDLE;
    int     m_age  = 0;      // cycles since LED came on
    int     m_rt   = 0;
    int     m_best = 255;

    // Elapsed ms while the LED has been on for `age` cycles.
    function automatic int ms_of(input int age);
        int v;
        v = age / TD;
        return (v > 255) ? 255 : v;
    endfunction

    initial begin
        int ms;
        bit cap;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_ph = M_IDLE; m_age = 0; m_rt = 0; m_best = 255;
            end
            check("m_delay_flag", int'(delay_flag), int'(m_ph == M_ARM || m_ph == M_GO));
            check("m_busy", int'(busy), int'(m_ph == M_ARM || m_ph == M_GO));
            check("m_led_on", int'(led_on), int'(m_ph == M_GO));
            check("m_result_valid", int'(result_valid), int'(m_ph == M_RES));
            check("m_foul", int'(foul), int'(m_ph == M_FOUL));
            check("m_timeout", int'(timeout), int'(m_ph == M_TOUT));
            check("m_react_time", int'(react_time), m_rt);
            check("m_best_time", int'(best_time), m_best);
            if (!rst) begin
                cap = 1'b0;
                ms  = ms_of(m_age);
                case (m_ph)
                    M_IDLE, M_FOUL, M_TOUT: if (start_btn) m_ph = M_ARM;
                    M_ARM: begin
                        if (react_btn) m_ph = M_FOUL;
                        else if (delay_done) begin m_ph = M_GO; m_age = 0; end
                    end
                    M_GO: begin
                        if (react_btn) begin m_rt = ms; cap = 1'b1; m_ph = M_RES; end
                        else if (ms >= TO) m_ph = M_TOUT;
                        else m_age++;
                    end
                    default: m_ph = M_IDLE;
                endcase
                if (cap && (clear_best || ms < m_best)) m_best = ms;
                else if (clear_best) m_best = 255;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arms a round, raises delay_done after dly ARM cycles and (optionally)
    // reacts in GO cycle react_at. Returns in the RESULT cycle when reacting,
    // otherwise in GO cycle 0 with delay_done still high.
    task automatic round(input int dly, input int react_at, input bit with_clear,
                         input bit do_react);
        start_btn = 1'b1; step(); start_btn = 1'b0;
        repeat (dly) step();
        delay_done = 1'b1; step();
        if (do_react) begin
            repeat (react_at) step();
            react_btn = 1'b1; clear_best = with_clear; step();
            react_btn = 1'b0; clear_best = 1'b0; delay_done = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) step();
        check("rst_best", int'(best_time), 255);
        check("rst_react", int'(react_time), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_flag", int'(delay_flag), 0);
        rst = 1'b0; step();

        // react in IDLE does nothing
        react_btn = 1'b1; step(); react_btn = 1'b0;
        check("idle_react_busy", int'(busy), 0);

        // 14 cycles into GO -> 3 ms
        round(20, 14, 1'b0, 1'b1);
        check("r1_valid", int'(result_valid), 1);
        check("r1_time", int'(react_time), 3);
        check("r1_best", int'(best_time), 3);
        step();
        check("r1_valid_drop", int'(result_valid), 0);

        // 6 ms does not beat 3 ms
        round(5, 24, 1'b0, 1'b1);
        check("r2_time", int'(react_time), 6);
        check("r2_best", int'(best_time), 3);
        step();
        clear_best = 1'b1; step(); clear_best = 1'b0;
        check("clear_best", int'(best_time), 255);

        round(3, 9, 1'b0, 1'b1);
        check("r3_time", int'(react_time), 2);
        check("r3_best", int'(best_time), 2);
        step();

        // clear_best with a slower result: the new result becomes best
        round(3, 30, 1'b1, 1'b1);
        check("r4_time", int'(react_time), 7);
        check("r4_best", int'(best_time), 7);
        step();

        // early press in ARM
        start_btn = 1'b1; step(); start_btn = 1'b0;
        repeat (2) step();
        react_btn = 1'b1; step(); react_btn = 1'b0;
        check("foul_set", int'(foul), 1);
        check("foul_flag", int'(delay_flag), 0);
        check("foul_led", int'(led_on), 0);
        step();
        start_btn = 1'b1; step(); start_btn = 1'b0;
        check("foul_restart", int'(foul), 0);
        check("foul_rearm", int'(busy), 1);

        // react and delay_done together in ARM -> foul
        react_btn = 1'b1; delay_done = 1'b1; step();
        react_btn = 1'b0; delay_done = 1'b0;
        check("tie_arm_foul", int'(foul), 1);
        check("tie_arm_led", int'(led_on), 0);
        step();

        // no reaction: count hits 10 in GO cycle 40, TOUT from cycle 41
        round(2, 0, 1'b0, 1'b0);
        repeat (40) step();
        check("tout_led_c40", int'(led_on), 1);
        check("tout_flag_c40", int'(timeout), 0);
        step();
        check("tout_set", int'(timeout), 1);
        check("tout_led", int'(led_on), 0);
        check("tout_react_keep", int'(react_time), 7);
        delay_done = 1'b0; step();

        // react in the timeout cycle wins with the 10 ms count
        round(4, 40, 1'b0, 1'b1);
        check("tie_go_valid", int'(result_valid), 1);
        check("tie_go_time", int'(react_time), 10);
        check("tie_go_best", int'(best_time), 7);
        step();

        // reset in the middle of GO
        round(2, 0, 1'b0, 1'b0);
        repeat (5) step();
        rst = 1'b1; #1;
        check("arst_led", int'(led_on), 0);
        check("arst_flag", int'(delay_flag), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_best", int'(best_time), 255);
        step();
        rst = 1'b0; delay_done = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
